rs_enc: RTL and testbench

Systematic Reed-Solomon encoder over GF(2^SYMB_WIDTH), using gf_pkg field arithmetic (gf_mult, alpha_to_symb). It is the transmit-side counterpart of the RS decoder chain (syndrome, Berlekamp-Massey, Chien, correction). Message symbols stream in and pass through unchanged to the output. Once the message ends, 2*T_LEN parity symbols are appended, computed by an LFSR division by g(x) = prod_{i=0}^{2T_LEN-1} (x + alpha^i). This root set matches the alpha^0-based evaluation used on the decoder side.

---
 rtl/rs_enc.sv | 140 ++++++++++++++
 tb/tb_rs_enc.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_enc.sv
// Systematic Reed-Solomon encoder over GF(2^SYMB_WIDTH): message symbols pass through,
// then 2*T_LEN parity symbols from an LFSR division by prod (x + alpha^i), i = 0..2T_LEN-1.
module rs_enc #(
  parameter int SYMB_WIDTH = 8,
  parameter int N_LEN      = 255,
  parameter int K_LEN      = 239,
  parameter int PRIM_POLY  = 'h11D
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [SYMB_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [SYMB_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  len_err
);

  // Both streams use valid/ready: a beat transfers on a rising aclk edge where valid
  // and ready are both high; once valid rises, data/last hold until that transfer.

  localparam int T_LEN = (N_LEN - K_LEN) / 2;
  localparam int NPAR  = 2 * T_LEN;
  localparam int CW    = $clog2(K_LEN + 1);
  localparam int PW    = $clog2(NPAR + 1);

  typedef logic [SYMB_WIDTH-1:0] symb_t;
  typedef logic [NPAR:0][SYMB_WIDTH-1:0] poly_t;
  typedef enum logic {ST_MSG, ST_PAR} state_t;

  function automatic symb_t gf_mult(input symb_t a, input symb_t b);
    symb_t p;
    symb_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SYMB_WIDTH-1] ? ((x << 1) ^ symb_t'(PRIM_POLY)) : (x << 1);
    end
    return p;
  endfunction

  function automatic symb_t alpha_to_symb(input int e);
    symb_t p;
    p = symb_t'(1);
    for (int i = 0; i < e; i++) p = gf_mult(p, symb_t'(2));
    return p;
  endfunction

  // Expand the generator one root at a time; coefficient NPAR stays 1 (monic).
  function automatic poly_t gen_poly();
    poly_t c;
    symb_t a;
    c    = '0;
    c[0] = symb_t'(1);
    for (int i = 0; i < NPAR; i++) begin
      a = alpha_to_symb(i);
      for (int j = NPAR; j > 0; j--) c[j] = c[j-1] ^ gf_mult(c[j], a);
      c[0] = gf_mult(c[0], a);
    end
    return c;
  endfunction

  localparam poly_t G = gen_poly();

  state_t                       state, state_nxt;
  logic [NPAR-1:0][SYMB_WIDTH-1:0] par, par_acc;
  logic [CW-1:0]                msg_cnt;
  logic [PW-1:0]                par_cnt;
  symb_t                        fb;
  logic                         out_free, accept, par_load, msg_last, par_final;

  // State register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= ST_MSG;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_MSG: if (accept && (s_tlast || msg_last)) state_nxt = ST_PAR;
      ST_PAR: if (par_load && par_final)          state_nxt = ST_MSG;
      default: state_nxt = ST_MSG;
    endcase
  end

  // Output / control decode
  always_comb begin
    out_free  = ~m_tvalid | m_tready;
    s_tready  = (state == ST_MSG) & out_free;
    accept    = s_tvalid & s_tready;
    par_load  = (state == ST_PAR) & out_free;
    msg_last  = (msg_cnt == CW'(K_LEN - 1));
    par_final = (par_cnt == PW'(NPAR - 1));
  end

  // One gf_mult plus one XOR per stage on the accept path.
  always_comb begin
    fb         = s_tdata ^ par[NPAR-1];
    par_acc    = '0;
    par_acc[0] = gf_mult(fb, G[0]);
    for (int j = 1; j < NPAR; j++) par_acc[j] = par[j-1] ^ gf_mult(fb, G[j]);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      par      <= '0;
      msg_cnt  <= '0;
      par_cnt  <= '0;
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      len_err <= accept & msg_last & ~s_tlast;
      if (accept) begin
        par      <= par_acc;
        msg_cnt  <= (s_tlast || msg_last) ? '0 : msg_cnt + CW'(1);
        m_tdata  <= s_tdata;
        m_tvalid <= 1'b1;
        m_tlast  <= 1'b0;
      end else if (par_load) begin
        // Shifting out parity leaves the register all-zero for the next block.
        par      <= {par[NPAR-2:0], symb_t'(0)};
        par_cnt  <= par_final ? '0 : par_cnt + PW'(1);
        m_tdata  <= par[NPAR-1];
        m_tvalid <= 1'b1;
        m_tlast  <= par_final;
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rs_enc.sv
// Directed bench for rs_enc with T_LEN=1 (g = x^2+3x+2 over 0x11D): hand-computed codewords,
// syndrome checks on random blocks, stalls, forced block end, back-to-back blocks, reset in parity.
module tb_rs_enc;
  localparam int W = 8;
  localparam int K = 253;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [W-1:0] s_tdata;
  logic         s_tvalid, s_tready, s_tlast;
  logic [W-1:0] m_tdata;
  logic         m_tvalid, m_tready, m_tlast, len_err;

  rs_enc #(.SYMB_WIDTH(W), .N_LEN(255), .K_LEN(K), .PRIM_POLY('h11D)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
    .len_err(len_err)
  );

  // Clock / cycle counter
  always #5 aclk = ~aclk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rdy_mode = 0;
  int tlast_cnt, len_err_cnt, len_err_at, stall_cnt, stall_viol;
  logic [W-1:0] out_d[$];
  logic         out_l[$];
  int           out_c[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] msg[$];
  logic [W-1:0] ref_q[$];

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (rdy_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // Output monitor, sampled mid-cycle
  initial begin
    logic         prev_stall;
    logic [W-1:0] prev_d;
    logic         prev_l;
    prev_stall = 1'b0;
    prev_d = '0;
    prev_l = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (m_tvalid !== 1'b1 || m_tdata !== prev_d || m_tlast !== prev_l))
          stall_viol++;
        if (m_tvalid && !m_tready) stall_cnt++;
        prev_stall = m_tvalid && !m_tready;
        prev_d = m_tdata;
        prev_l = m_tlast;
        if (len_err) begin
          len_err_cnt++;
          len_err_at = out_d.size();
        end
        if (m_tvalid && m_tready) begin
          out_d.push_back(m_tdata);
          out_l.push_back(m_tlast);
          out_c.push_back(cyc);
          if (m_tlast) tlast_cnt++;
        end
      end
    end
  end

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[W-1] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [W-1:0] synd(input int off, input int n, input logic [W-1:0] root);
    logic [W-1:0] s;
    s = '0;
    for (int i = 0; i < n; i++) s = gf_mul(s, root) ^ out_d[off+i];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    out_d.delete();
    out_l.delete();
    out_c.delete();
    tlast_cnt = 0;
    len_err_cnt = 0;
    len_err_at = -1;
    stall_cnt = 0;
    stall_viol = 0;
  endtask

  // Driver tasks
  task automatic send_sym(input logic [W-1:0] d, input logic l);
    logic acc;
    int   k;
    acc = 1'b0;
    k = 0;
    s_tvalid = 1'b1;
    s_tdata = d;
    s_tlast = l;
    while (!acc && k < 200) begin
      @(negedge aclk);
      acc = s_tready;
      @(posedge aclk);
      #1;
      k++;
    end
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic send_msg(input logic use_tlast);
    for (int i = 0; i < msg.size(); i++) send_sym(msg[i], use_tlast && (i == msg.size() - 1));
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (out_d.size() < n && k < 3000) begin
      @(posedge aclk);
      k++;
    end
    repeat (5) @(posedge aclk);
    #1;
  endtask

  task automatic rand_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(W'($urandom_range(0, 255)));
  endtask

  // Scoreboard against exp_q
  task automatic chk_exp(input string tag);
    chk({tag, "_len"}, 32'(out_d.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_d.size(); i++) begin
      chk($sformatf("%s_d%0d", tag, i), 32'(out_d[i]), 32'(exp_q[i]));
      chk($sformatf("%s_l%0d", tag, i), 32'(out_l[i]), 32'(i == exp_q.size() - 1));
    end
  endtask

  // Message passthrough, m_tlast position and zero syndromes at alpha^0, alpha^1
  task automatic chk_cw(input string tag, input int out_off, input int msg_off, input int mlen);
    if (out_d.size() >= out_off + mlen + 2) begin
      for (int i = 0; i < mlen; i++)
        chk($sformatf("%s_m%0d", tag, i), 32'(out_d[out_off+i]), 32'(msg[msg_off+i]));
      chk({tag, "_lastpos"}, 32'(out_l[out_off+mlen+1]), 32'd1);
      chk({tag, "_notlast"}, 32'(out_l[out_off+mlen]), 32'd0);
      chk({tag, "_s0"}, 32'(synd(out_off, mlen + 2, 8'h01)), 32'd0);
      chk({tag, "_s1"}, 32'(synd(out_off, mlen + 2, 8'h02)), 32'd0);
    end else begin
      chk({tag, "_short"}, 32'(out_d.size()), 32'(out_off + mlen + 2));
    end
  endtask

  initial begin
    s_tvalid = 1'b0;
    s_tdata = '0;
    s_tlast = 1'b0;
    clr();
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
    chk("rst_s_tready", 32'(s_tready), 32'd1);
    @(posedge aclk);
    #1;

    // Hand-computed single- and two-symbol codewords
    clr();
    msg = {8'h01};
    exp_q = {8'h01, 8'h03, 8'h02};
    send_msg(1'b1);
    wait_out(3);
    chk_exp("a");
    chk("a_len_err", 32'(len_err_cnt), 32'd0);

    clr();
    msg = {8'h01, 8'h01};
    exp_q = {8'h01, 8'h01, 8'h04, 8'h04};
    send_msg(1'b1);
    wait_out(4);
    chk_exp("b");

    clr();
    msg = {8'h80};
    exp_q = {8'h80, 8'h9D, 8'h1D};
    send_msg(1'b1);
    wait_out(3);
    chk_exp("c");

    // Full-length all-zero block
    clr();
    msg.delete();
    exp_q.delete();
    for (int i = 0; i < K; i++) msg.push_back(8'h00);
    for (int i = 0; i < K + 2; i++) exp_q.push_back(8'h00);
    send_msg(1'b1);
    wait_out(K + 2);
    chk_exp("d");
    chk("d_tlast_cnt", 32'(tlast_cnt), 32'd1);

    // Random full block: stall-free, then with random backpressure
    clr();
    rand_msg(K);
    send_msg(1'b1);
    wait_out(K + 2);
    chk_cw("e", 0, 0, K);
    chk("e_len_err", 32'(len_err_cnt), 32'd0);
    ref_q = out_d;
    clr();
    rdy_mode = 1;
    send_msg(1'b1);
    wait_out(K + 2);
    rdy_mode = 0;
    chk("e_stall_len", 32'(out_d.size()), 32'(ref_q.size()));
    for (int i = 0; i < ref_q.size() && i < out_d.size(); i++)
      chk($sformatf("e_stall_d%0d", i), 32'(out_d[i]), 32'(ref_q[i]));
    chk("e_stall_hold", 32'(stall_viol), 32'd0);
    chk("e_stalls_seen", 32'(stall_cnt > 0), 32'd1);
    chk("e_stall_tlast", 32'(tlast_cnt), 32'd1);

    // K symbols without s_tlast: forced end, then a short block
    clr();
    rand_msg(K);
    send_msg(1'b0);
    wait_out(K + 2);
    chk("f_len_err_cnt", 32'(len_err_cnt), 32'd1);
    chk("f_len_err_at", 32'(len_err_at), 32'(K - 1));
    chk("f_len", 32'(out_d.size()), 32'(K + 2));
    chk_cw("f", 0, 0, K);
    clr();
    rand_msg(10);
    send_msg(1'b1);
    wait_out(12);
    chk("f2_len", 32'(out_d.size()), 32'd12);
    chk_cw("f2", 0, 0, 10);
    chk("f2_len_err", 32'(len_err_cnt), 32'd0);

    // Back-to-back shortened blocks of 5 and 17
    clr();
    rand_msg(22);
    for (int i = 0; i < 22; i++) send_sym(msg[i], (i == 4) || (i == 21));
    wait_out(26);
    chk("g_len", 32'(out_d.size()), 32'd26);
    chk("g_tlast_cnt", 32'(tlast_cnt), 32'd2);
    chk_cw("g1", 0, 0, 5);
    chk_cw("g2", 7, 5, 17);
    if (out_c.size() == 26) chk("g_no_gap", 32'(out_c[25] - out_c[0]), 32'd25);
    else chk("g_no_gap_size", 32'(out_c.size()), 32'd26);

    // Reset while parity is being emitted
    clr();
    msg = {8'h01};
    send_msg(1'b1);
    @(posedge aclk);
    #1;
    chk("h_pre_par", 32'(m_tdata), 32'h03);
    aresetn = 1'b0;
    #1;
    chk("h_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("h_rst_tdata", 32'(m_tdata), 32'd0);
    chk("h_rst_tlast", 32'(m_tlast), 32'd0);
    chk("h_rst_len_err", 32'(len_err), 32'd0);
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    clr();
    msg = {8'h80};
    exp_q = {8'h80, 8'h9D, 8'h1D};
    send_msg(1'b1);
    wait_out(3);
    chk_exp("h");
    chk("h_tlast_cnt", 32'(tlast_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=%0d expected=done", cyc);
    $fatal(1, "timeout");
  end

endmodule
